// File: rtl/sram_pkg.sv
// Shared types and widths for the IS61WV25616 responder and its monitor.
// Cycle classes, error codes and a byte-lane mask helper live here.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        CycIdle,
        CycWrite,
        CycRead
    } sram_cyc_e;

    typedef enum logic [1:0] {
        ErrNone,
        ErrRange,
        ErrContend,
        ErrNoLane
    } sram_err_e;

    // Expand a two-bit lane enable into a 16-bit data mask.
    function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [1:0] lanes);
        return {{8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/sram_resp_monitor.sv
// Classifies each pin cycle, qualifies writes/reads, and keeps the access
// counters plus the sticky first-error record.
module sram_resp_monitor
    import sram_pkg::*;
#(
    parameter bit IGNORE_OE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        ce_n,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic        lb_n,
    input  logic        ub_n,
    input  logic        in_range,
    output sram_cyc_e   cyc,
    output logic        wr_commit,
    output logic        rd_access,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt,
    output logic        err,
    output logic [1:0]  err_code
);

    logic      lanes_on;
    logic      contend;
    sram_err_e err_now;

    always_comb begin
        lanes_on = !lb_n || !ub_n;
        contend  = !ce_n && !we_n && !oe_n;

        cyc = CycIdle;
        if (!ce_n) begin
            if (!we_n)
                cyc = CycWrite;
            else if (IGNORE_OE || !oe_n)
                cyc = CycRead;
        end

        wr_commit = (cyc == CycWrite) && lanes_on && in_range;
        rd_access = (cyc == CycRead) && lanes_on && in_range;

        // Priority order gives the lowest code when several errors coincide.
        err_now = ErrNone;
        if (!ce_n && !in_range)
            err_now = ErrRange;
        else if (contend)
            err_now = ErrContend;
        else if (!ce_n && !lanes_on)
            err_now = ErrNoLane;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_cnt   <= 32'd0;
            rd_cnt   <= 32'd0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            if (wr_commit)
                wr_cnt <= wr_cnt + 32'd1;
            if (rd_access)
                rd_cnt <= rd_cnt + 32'd1;
            if (!err && (err_now != ErrNone)) begin
                err      <= 1'b1;
                err_code <= err_now;
            end
        end
    end

endmodule

// File: rtl/sram_is61wv25616_responder.sv
// Device-side model of an IS61WV25616 SRAM: byte-laned word array, read path
// with optional one-cycle latency, and a bench backdoor port.
module sram_is61wv25616_responder
    import sram_pkg::*;
#(
    parameter int DEPTH     = 262144,
    parameter bit READ_LAT  = 1'b0,
    parameter bit IGNORE_OE = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_I,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_O,
    output logic [1:0]             SRAM_DQ_OE,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_OE_N,
    input  logic                   SRAM_LB_N,
    input  logic                   SRAM_UB_N,
    input  logic [SRAM_ADDR_W-1:0] i_bd_addr,
    output logic [SRAM_DATA_W-1:0] o_bd_data,
    output logic [31:0]            o_wr_cnt,
    output logic [31:0]            o_rd_cnt,
    output logic                   o_err,
    output logic [1:0]             o_err_code
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SRAM_ADDR_W:0] DEPTH_L = DEPTH[SRAM_ADDR_W:0];

    logic [SRAM_DATA_W-1:0] mem [DEPTH];

    logic             in_range;
    logic             bd_in_range;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lanes;
    sram_cyc_e        cyc;
    logic             wr_commit;
    logic             rd_access;
    logic [SRAM_DATA_W-1:0] dq_raw;
    logic [1:0]             oe_raw;

    assign in_range    = {1'b0, SRAM_ADDR} < DEPTH_L;
    assign bd_in_range = {1'b0, i_bd_addr} < DEPTH_L;
    assign idx         = SRAM_ADDR[IDX_W-1:0];
    assign lanes       = {~SRAM_UB_N, ~SRAM_LB_N};

    sram_resp_monitor #(
        .IGNORE_OE (IGNORE_OE)
    ) u_monitor (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .ce_n      (SRAM_CE_N),
        .we_n      (SRAM_WE_N),
        .oe_n      (SRAM_OE_N),
        .lb_n      (SRAM_LB_N),
        .ub_n      (SRAM_UB_N),
        .in_range  (in_range),
        .cyc       (cyc),
        .wr_commit (wr_commit),
        .rd_access (rd_access),
        .wr_cnt    (o_wr_cnt),
        .rd_cnt    (o_rd_cnt),
        .err       (o_err),
        .err_code  (o_err_code)
    );

    // The array is never reset; a write sampled while reset is high is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_reset && wr_commit) begin
            if (!SRAM_LB_N)
                mem[idx][7:0] <= SRAM_DQ_I[7:0];
            if (!SRAM_UB_N)
                mem[idx][15:8] <= SRAM_DQ_I[15:8];
        end
    end

    generate
        if (READ_LAT) begin : g_rd_reg
            logic             rd_q;
            logic             range_q;
            logic [IDX_W-1:0] idx_q;
            logic [1:0]       lanes_q;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    rd_q    <= 1'b0;
                    range_q <= 1'b0;
                    idx_q   <= '0;
                    lanes_q <= 2'b00;
                end else begin
                    rd_q    <= (cyc == CycRead);
                    range_q <= in_range;
                    idx_q   <= idx;
                    lanes_q <= lanes;
                end
            end

            always_comb begin
                oe_raw = rd_q ? lanes_q : 2'b00;
                dq_raw = (rd_q && range_q) ? (mem[idx_q] & lane_mask(lanes_q)) : '0;
            end
        end else begin : g_rd_comb
            always_comb begin
                oe_raw = (cyc == CycRead) ? lanes : 2'b00;
                dq_raw = in_range ? (mem[idx] & lane_mask(oe_raw)) : '0;
            end
        end
    endgenerate

    // Reset silences the bus immediately, including the combinational path.
    assign SRAM_DQ_OE = i_reset ? 2'b00 : oe_raw;
    assign SRAM_DQ_O  = i_reset ? '0 : dq_raw;

    assign o_bd_data = bd_in_range ? mem[i_bd_addr[IDX_W-1:0]] : '0;

endmodule
